// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding, digit-correction constants and helpers for the sequential BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_OFFSET = 4'd3;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: single BCD digit correction, adds 3 when the digit is 5 or more before the next shift
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_d,
    output logic [BCD_DIGIT_W-1:0] o_d
);

    assign o_d = (i_d >= ADD3_THRESH) ? i_d + ADD3_OFFSET : i_d;

endmodule

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: one-bit-per-clock double-dabble converter with valid/ready on both sides; define BCD_SEQ_OVF_EN to add the out_ovf overflow flag
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          busy
`ifdef BCD_SEQ_OVF_EN
    ,
    output logic                          out_ovf
`endif
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [BW-1:0]    r_bcd;
    logic [BW-1:0]    w_adj;
    logic [WIDTH-1:0] r_bin;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_take;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign out_bcd   = r_bcd;
    assign w_accept  = in_valid && in_ready;
    assign w_take    = out_valid && out_ready;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .i_d(r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_d(w_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state: accept in IDLE, finish after the last shift, release on the output handshake
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_accept)        w_next = SHIFT;
        if (r_state == SHIFT && r_cnt == '0)    w_next = DONE;
        if (r_state == DONE && w_take)          w_next = IDLE;
    end

    // datapath: load on accept, then correct digits and shift {bcd, bin} left once per SHIFT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bcd <= '0;
            r_bin <= in_bin;
            r_cnt <= CW'(WIDTH - 1);
        end else if (r_state == SHIFT) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt          <= r_cnt - 1'b1;
        end
    end

`ifdef BCD_SEQ_OVF_EN
    localparam longint unsigned BCD_MAX = pow10(DIGITS) - 1;

    logic r_ovf;

    // overflow flag captured at acceptance and dropped once the result is taken
    always_ff @(posedge clk) begin
        if (rst)           r_ovf <= 1'b0;
        else if (w_accept) r_ovf <= 64'(in_bin) > BCD_MAX;
        else if (w_take)   r_ovf <= 1'b0;
    end

    assign out_ovf = r_ovf && out_valid;
`else
    if (pow10(DIGITS) <= (64'd1 << WIDTH) - 64'd1) begin : g_cfg_err
        $error("bcd_convert_seq: DIGITS cannot hold the largest WIDTH-bit value");
    end
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb_bcd_convert_seq: randomized and directed checks of the sequential BCD converter against a latency/value model
module tb_bcd_convert_seq;

    localparam int WIDTH = 8;
`ifdef BCD_SEQ_OVF_EN
    localparam int DIGITS = 2;
`else
    localparam int DIGITS = 3;
`endif
    localparam int BW = 4 * DIGITS;
    localparam int unsigned LIMIT = 10 ** DIGITS;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] in_bin    = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [BW-1:0]    out_bcd;
`ifdef BCD_SEQ_OVF_EN
    logic             out_ovf;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bcd  (out_bcd),
        .busy     (busy)
`ifdef BCD_SEQ_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    typedef enum int {M_IDLE, M_CONV, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    int          m_due  = 0;
    int unsigned m_val  = 0;
    bit          m_zero = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) xfers <= xfers + 1;
        if (rst) begin
            m_mode <= M_IDLE;
            m_zero <= 1'b1;
        end else if (m_mode == M_IDLE && in_valid) begin
            m_mode <= M_CONV;
            m_val  <= in_bin;
            m_due  <= cyc + 1 + WIDTH;
            m_zero <= 1'b0;
        end else if (m_mode == M_CONV && cyc + 1 == m_due) begin
            m_mode <= M_DONE;
        end else if (m_mode == M_DONE && out_ready) begin
            m_mode <= M_IDLE;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_mode == M_IDLE && !rst);
        chk("out_valid", out_valid, m_mode == M_DONE);
        chk("busy", busy, m_mode != M_IDLE);
        if (m_mode == M_DONE) chk("out_bcd", out_bcd, to_bcd(m_val));
        if (m_mode == M_IDLE && m_zero) chk("out_bcd_zero", out_bcd, 0);
`ifdef BCD_SEQ_OVF_EN
        chk("out_ovf", out_ovf, m_mode == M_DONE && m_val >= LIMIT);
`endif
    end

    task automatic wait_ready();
        int lim;
        lim = 0;
        while (!in_ready && lim < 100) begin
            @(posedge clk);
            #1;
            lim++;
        end
        chk("wait_ready", in_ready, 1);
    endtask

    task automatic run(input int unsigned val, input logic [BW-1:0] exp, input int stall, input bit tput);
        int t0, lim, x0;
        wait_ready();
        in_valid = 1'b1;
        in_bin   = WIDTH'(val);
        @(posedge clk);
        #1;
        t0       = cyc;
        in_valid = 1'b0;
        lim      = 0;
        while (!out_valid && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        chk("latency", cyc - t0, WIDTH);
        chk("result", out_bcd, exp);
        if (stall > 0) begin
            out_ready = 1'b0;
            x0 = xfers;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_valid", out_valid, 1);
                chk("stall_bcd", out_bcd, exp);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("release_valid", out_valid, 0);
            chk("single_xfer", xfers - x0, 1);
        end else if (tput) begin
            lim = 0;
            while (!in_ready && lim < 100) begin
                @(negedge clk);
                lim++;
            end
            chk("throughput", cyc - t0, WIDTH + 1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_bcd", out_bcd, 0);
`ifdef BCD_SEQ_OVF_EN
        chk("reset_out_ovf", out_ovf, 0);
        run(150, 8'h50, 0, 1'b0);
        run(99, 8'h99, 3, 1'b0);
        run(0, 8'h00, 0, 1'b1);
`else
        run(0, 12'h000, 0, 1'b1);
        run(255, 12'h255, 0, 1'b0);
        run(99, 12'h099, 0, 1'b0);
        run(10, 12'h010, 0, 1'b0);
        run(137, 12'h137, 5, 1'b0);
`endif
        wait_ready();
        in_valid = 1'b1;
        in_bin   = WIDTH'(200);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_bcd", out_bcd, 0);
        chk("abort_in_ready", in_ready, 1);
`ifdef BCD_SEQ_OVF_EN
        run(42, 8'h42, 0, 1'b0);
`else
        run(42, 12'h042, 0, 1'b0);
`endif
        in_valid = 1'b1;
        repeat (30) begin
            in_bin = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3000) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            in_bin    = WIDTH'($urandom);
            rst       = $urandom_range(0, 299) == 0;
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (WIDTH + 4) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
